// File: rtl/shift_register_pipe.sv
// shift_register_pipe
// Serial-in / serial-out shift register with a parallel load and a word
// pipeline of DEPTH stages behind it. Stage 0 is the shift stage. Every
// stage moves together whenever the register advances, which happens on a
// load or a shift. DATA_OUT taps the last stage.
//
// A bit counter tracks serial word boundaries. WORD_DONE pulses for one cycle
// when stage 0 holds a complete serial word. A fill counter raises DATA_VALID
// once the pipeline has been filled since reset.
//
// Optional build macro: SHIFT_REG_PARITY_EN
//   When it is defined, PARITY_OUT is added. It is the even parity of the
//   word on DATA_OUT. The parity bit is computed as stage 0 is written and
//   then travels down the pipeline with its word.
module shift_register_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SHIFT_EN,
    input  logic             DIR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             DATA_IN,
    output logic             SHIFT_OUT,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             WORD_DONE
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             PARITY_OUT
`endif
);

    localparam int BW = $clog2(WIDTH);
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

    logic             advance;
    logic [WIDTH-1:0] stage0_next;
    logic [WIDTH-1:0] stage_p [DEPTH];
    logic [BW-1:0]    bit_cnt;
    logic [FW-1:0]    fill_cnt;
    logic             word_done_r;

    // Next value of the shift stage: a load wins over a shift, and DIR picks the end that DATA_IN enters
    always_comb begin
        advance     = LOAD | SHIFT_EN;
        stage0_next = stage_p[0];
        if (LOAD) begin
            stage0_next = LOAD_DATA;
        end else if (DIR) begin
            stage0_next = {DATA_IN, stage_p[0][WIDTH-1:1]};
        end else begin
            stage0_next = {stage_p[0][WIDTH-2:0], DATA_IN};
        end
    end

    // Word pipeline: all stages move together on every advance and hold otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_p[k] <= '0;
            end
        end else if (advance) begin
            stage_p[0] <= stage0_next;
            for (int k = 1; k < DEPTH; k++) begin
                stage_p[k] <= stage_p[k-1];
            end
        end
    end

    // Fill counter saturates after DEPTH-1 advances, so the first word has reached DATA_OUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_cnt <= '0;
        end else if (advance && (fill_cnt != FILL_LAST)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Bit counter marks serial word boundaries; a load restarts the count at bit 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt     <= '0;
            word_done_r <= 1'b0;
        end else if (LOAD) begin
            bit_cnt     <= '0;
            word_done_r <= 1'b0;
        end else if (SHIFT_EN) begin
            if (bit_cnt == BIT_LAST) begin
                bit_cnt     <= '0;
                word_done_r <= 1'b1;
            end else begin
                bit_cnt     <= bit_cnt + 1'b1;
                word_done_r <= 1'b0;
            end
        end else begin
            word_done_r <= 1'b0;
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    logic par_p [DEPTH];

    // Parity travels beside each word, so PARITY_OUT stays aligned with DATA_OUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                par_p[k] <= 1'b0;
            end
        end else if (advance) begin
            par_p[0] <= ^stage0_next;
            for (int k = 1; k < DEPTH; k++) begin
                par_p[k] <= par_p[k-1];
            end
        end
    end

    assign PARITY_OUT = par_p[DEPTH-1];
`endif

    assign SHIFT_OUT  = DIR ? stage_p[0][0] : stage_p[0][WIDTH-1];
    assign DATA_OUT   = stage_p[DEPTH-1];
    assign DATA_VALID = (fill_cnt == FILL_LAST);
    assign WORD_DONE  = word_done_r;

endmodule

// File: tb/tb_shift_register_pipe.sv
// Testbench for shift_register_pipe with WIDTH=8 and DEPTH=3.
// It runs three parts: a table of directed vectors, a hand-written sequence
// that counts word boundaries, and a randomized run against a word-level
// reference model.
module tb_shift_register_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sh = 1'b0;
    logic         dir = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] ldata = '0;
    logic         din = 1'b0;
    logic         sout;
    logic [W-1:0] dout;
    logic         vld;
    logic         wd;
`ifdef SHIFT_REG_PARITY_EN
    logic         par;
`endif

    int n_vec = 0;
    int n_err = 0;

    shift_register_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK       (clk),
        .RST       (rst),
        .SHIFT_EN  (sh),
        .DIR       (dir),
        .LOAD      (ld),
        .LOAD_DATA (ldata),
        .DATA_IN   (din),
        .SHIFT_OUT (sout),
        .DATA_OUT  (dout),
        .DATA_VALID(vld),
        .WORD_DONE (wd)
`ifdef SHIFT_REG_PARITY_EN
        ,
        .PARITY_OUT(par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         sh;
        logic         dir;
        logic         ld;
        logic [W-1:0] ldata;
        logic         din;
        logic [W-1:0] e_dout;
        logic         e_sout;
        logic         e_vld;
        logic         e_wd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic dr, input logic l,
                       input logic [W-1:0] ldv, input logic di, input logic [W-1:0] edo,
                       input logic eso, input logic ev, input logic ew);
        tbl.push_back(vec_t'{r, s, dr, l, ldv, di, edo, eso, ev, ew});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic dr, input logic l,
                         input logic [W-1:0] ldv, input logic di);
        rst = r; sh = s; dir = dr; ld = l; ldata = ldv; din = di;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [W-1:0] edo, input logic eso,
                            input logic ev, input logic ew);
        chk({tag, "_dout"}, 32'(dout), 32'(edo));
        chk({tag, "_sout"}, 32'(sout), 32'(eso));
        chk({tag, "_valid"}, 32'(vld), 32'(ev));
        chk({tag, "_wdone"}, 32'(wd), 32'(ew));
`ifdef SHIFT_REG_PARITY_EN
        chk({tag, "_par"}, 32'(par), 32'(^edo));
`endif
    endtask

    initial begin
        int           p1, p2, npulse;
        int unsigned  m0, m1, m2, fill, nb;
        bit           mwd;
        logic         r_rst, r_sh, r_dir, r_ld, r_din;
        logic [W-1:0] r_ldata;

        // reset, then idle with no advance
        add(1,0,0,0,8'h00,0, 8'h00,0,0,0);
        add(1,0,0,0,8'h00,0, 8'h00,0,0,0);
        add(0,0,0,0,8'h00,1, 8'h00,0,0,0);
        // shift left 1,0,1,1,0,0,1,0 -> stage0 B2
        add(0,1,0,0,8'h00,1, 8'h00,0,0,0);
        add(0,1,0,0,8'h00,0, 8'h00,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h01,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h02,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h05,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h0B,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h16,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h2C,1,1,1);
        add(0,0,0,0,8'h00,0, 8'h2C,1,1,0);
        // shift right with the same bits -> stage0 4D
        add(1,0,1,0,8'h00,0, 8'h00,0,0,0);
        add(1,0,1,0,8'h00,0, 8'h00,0,0,0);
        add(0,1,1,0,8'h00,1, 8'h00,0,0,0);
        add(0,1,1,0,8'h00,0, 8'h00,0,1,0);
        add(0,1,1,0,8'h00,1, 8'h80,0,1,0);
        add(0,1,1,0,8'h00,1, 8'h40,0,1,0);
        add(0,1,1,0,8'h00,0, 8'hA0,0,1,0);
        add(0,1,1,0,8'h00,0, 8'hD0,0,1,0);
        add(0,1,1,0,8'h00,1, 8'h68,0,1,0);
        add(0,1,1,0,8'h00,0, 8'h34,1,1,1);
        // three back-to-back loads, then idle with DATA_IN unknown
        add(1,0,0,0,8'h00,0, 8'h00,0,0,0);
        add(0,0,0,1,8'hA5,0, 8'h00,1,0,0);
        add(0,0,0,1,8'h3C,0, 8'h00,0,1,0);
        add(0,0,0,1,8'hFF,0, 8'hA5,1,1,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,8'h00,1'bx, 8'hA5,1,1,0);
        // load during shift has priority and restarts the bit count
        add(1,0,0,0,8'h00,0, 8'h00,0,0,0);
        add(0,1,0,0,8'h00,1, 8'h00,0,0,0);
        add(0,1,0,0,8'h00,1, 8'h00,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h01,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h03,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h07,0,1,0);
        add(0,1,0,1,8'h81,0, 8'h0F,1,1,0);
        add(0,1,0,0,8'h00,0, 8'h1F,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h81,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h02,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h04,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h08,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h10,0,1,0);
        add(0,1,0,0,8'h00,0, 8'h20,1,1,0);
        add(0,1,0,0,8'h00,0, 8'h40,0,1,1);
        // reset mid-word with the pipeline full, then the first shift after reset
        add(0,1,0,0,8'h00,1, 8'h80,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h00,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h01,0,1,0);
        add(0,1,0,0,8'h00,1, 8'h03,0,1,0);
        add(1,1,0,0,8'h00,1, 8'h00,0,0,0);
        add(0,1,0,0,8'h00,1, 8'h00,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].sh, tbl[i].dir, tbl[i].ld, tbl[i].ldata, tbl[i].din);
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_sout, tbl[i].e_vld, tbl[i].e_wd);
        end

        // 16 continuous right shifts after reset: exactly two pulses, 8 shifts apart
        drive(1,0,1,0,8'h00,0);
        step();
        p1 = -1; p2 = -1; npulse = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(0,1,1,0,8'h00,1'($urandom_range(1)));
            step();
            if (wd) begin
                npulse++;
                if (p1 < 0) p1 = i; else p2 = i;
            end
        end
        drive(0,0,1,0,8'h00,0);
        step();
        chk("wd_pulse_count", 32'(npulse), 32'd2);
        chk("wd_first_pos", 32'(p1), 32'd8);
        chk("wd_gap", 32'(p2 - p1), 32'd8);
        chk("wd_after_idle", 32'(wd), 32'd0);

        // randomized run against the word-level model
        drive(1,0,0,0,8'h00,0);
        step();
        m0 = 0; m1 = 0; m2 = 0; fill = 0; nb = 0; mwd = 0;
        for (int i = 0; i < 1500; i++) begin
            r_rst   = ($urandom_range(63) == 0);
            r_ld    = ($urandom_range(7) == 0);
            r_sh    = 1'($urandom_range(1));
            r_dir   = 1'($urandom_range(1));
            r_din   = 1'($urandom_range(1));
            r_ldata = W'($urandom);
            drive(r_rst, r_sh, r_dir, r_ld, r_ldata, r_din);
            step();
            if (r_rst) begin
                m0 = 0; m1 = 0; m2 = 0; fill = 0; nb = 0; mwd = 0;
            end else if (r_ld || r_sh) begin
                m2 = m1;
                m1 = m0;
                if (r_ld) m0 = r_ldata;
                else if (r_dir) m0 = (m0 / 2) + (r_din ? 128 : 0);
                else m0 = (m0 * 2 + r_din) % 256;
                if (fill < D - 1) fill++;
                if (r_ld) begin
                    nb = 0; mwd = 0;
                end else begin
                    nb++;
                    mwd = (nb == W);
                    if (nb == W) nb = 0;
                end
            end else begin
                mwd = 0;
            end
            chk_outs($sformatf("rnd%0d", i), W'(m2), r_dir ? 1'(m0 % 2) : 1'(m0 / 128),
                     (fill == D - 1), mwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register_pipe.md
Name: shift_register_pipe

Overview:
- Parametrised successor to the fixed 32-bit serial shift register with its 3-word output pipeline.
- Adds configurable width and pipeline depth, a clock enable (no longer clocked by the shift strobe), shift direction, parallel load, synchronous reset, a word-boundary counter and a pipeline-valid flag.
- Sits between serial links and word-oriented datapath logic, in either direction.

Parameters:
- WIDTH, 32, shift word width in bits (>=2).
- DEPTH, 3, number of word stages including the shift stage (>=1); DATA_OUT taps the last stage.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- SHIFT_EN  input  1  shift one bit this cycle.
- DIR  input  1  0 = shift left (MSB out, DATA_IN enters LSB); 1 = shift right (LSB out, DATA_IN enters MSB).
- LOAD  input  1  parallel load of stage 0 this cycle.
- LOAD_DATA  input  WIDTH  parallel load word.
- DATA_IN  input  1  serial input bit.
- SHIFT_OUT  output  1  serial output bit.
- DATA_OUT  output  WIDTH  last pipeline stage.
- DATA_VALID  output  1  pipeline filled since reset.
- WORD_DONE  output  1  one-cycle pulse after every WIDTH-th shift.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - all stages 0, so DATA_OUT=0 and SHIFT_OUT=0.
  - bit counter 0; WORD_DONE=0.
  - fill counter 0; DATA_VALID=0 if DEPTH>1, else 1.
- advance = LOAD | SHIFT_EN. When advance=0, all state holds.
- Stage 0 on advance:
  - LOAD=1: stage0 <= LOAD_DATA. LOAD has priority over SHIFT_EN when both are high; DATA_IN is ignored that cycle.
  - SHIFT_EN=1, DIR=0: stage0 <= {stage0[WIDTH-2:0], DATA_IN}.
  - SHIFT_EN=1, DIR=1: stage0 <= {DATA_IN, stage0[WIDTH-1:1]}.
- Stages k=1..DEPTH-1: stage[k] <= stage[k-1] (old value) on every advance. All stages move together with stage 0.
- DATA_OUT = stage[DEPTH-1], combinational from registers. DEPTH=1 gives DATA_OUT = stage0.
- Latency: a word loaded in cycle t appears on DATA_OUT after DEPTH-1 further advances.
- SHIFT_OUT is combinational: DIR ? stage0[0] : stage0[WIDTH-1], using the current DIR. Changing DIR mid-word is legal; no state is altered.
- Fill counter:
  - increments on advance, saturating at DEPTH-1.
  - DATA_VALID = (fill == DEPTH-1); stays high until RST.
- Bit counter (ceil(log2(WIDTH)) bits):
  - LOAD: counter <= 0; WORD_DONE <= 0.
  - SHIFT_EN without LOAD: if counter == WIDTH-1, counter <= 0 and WORD_DONE <= 1 (wrap); else counter increments and WORD_DONE <= 0.
  - otherwise WORD_DONE <= 0.
  - WORD_DONE is registered, high exactly one cycle, coincident with stage0 holding the completed serial word.
- Consecutive words: continuous shifting with no gap produces a WORD_DONE every WIDTH cycles.
- RST asserted mid-word or mid-fill discards all partial state; the first post-reset shift counts as bit 0.
- DATA_IN unknown with advance low must not corrupt state.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined:
  - extra output PARITY_OUT (1 bit) = registered even parity (XOR reduction) of stage[DEPTH-1], aligned with DATA_OUT.
  - implemented as a parity bit carried through the pipeline: computed from stage0's next value and advanced with each stage.
  - reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. WIDTH=8, DEPTH=3: RST for 2 cycles → DATA_OUT=0, SHIFT_OUT=0, DATA_VALID=0, WORD_DONE=0; then 1 cycle with LOAD and SHIFT_EN both low → all outputs unchanged.
2. WIDTH=8, DIR=0: shift bits 1,0,1,1,0,0,1,0 on 8 consecutive SHIFT_EN cycles → stage0=8'hB2; WORD_DONE high only in the cycle after the 8th shift; SHIFT_OUT after shift 8 = 1.
3. Same serial bits with DIR=1 → stage0=8'h4D, SHIFT_OUT=1; then 16 continuous shifts → exactly 2 WORD_DONE pulses, 8 cycles apart.
4. DEPTH=3: LOAD 8'hA5, then LOAD 8'h3C, then LOAD 8'hFF on consecutive cycles → DATA_OUT=8'hA5 and DATA_VALID=1 after the 3rd load; idle 5 cycles → DATA_OUT holds 8'hA5.
5. LOAD=1, SHIFT_EN=1, LOAD_DATA=8'h81 after 5 shifts → stage0=8'h81, bit counter 0; 8 more shifts needed before WORD_DONE.
6. RST after 4 shifts with DATA_VALID=1 → all outputs return to reset values next cycle. With SHIFT_REG_PARITY_EN: DATA_OUT=8'h07 gives PARITY_OUT=1; DATA_OUT=8'h03 gives PARITY_OUT=0.
